// File: rtl/alu_pkg.sv
// Shared definitions for the iterative ALU: op encodings, FSM states, default width.
package alu_pkg;

  localparam int XLEN_DEFAULT = 32;

  typedef enum logic [4:0] {
    OP_LUI   = 5'h00,
    OP_AUIPC = 5'h01,
    OP_ADD   = 5'h02,
    OP_BEQ   = 5'h03,
    OP_BNE   = 5'h04,
    OP_BLT   = 5'h05,
    OP_BGE   = 5'h06,
    OP_BLTU  = 5'h07,
    OP_BGEU  = 5'h08,
    OP_SLT   = 5'h09,
    OP_SLTU  = 5'h0A,
    OP_XOR   = 5'h0B,
    OP_OR    = 5'h0C,
    OP_AND   = 5'h0D,
    OP_SLL   = 5'h0E,
    OP_SRL   = 5'h0F,
    OP_SRA   = 5'h10,
    OP_SUB   = 5'h11,
    OP_ZERO  = 5'h12,
    OP_MUL   = 5'h13,
    OP_DIV   = 5'h14,
    OP_DIVU  = 5'h15,
    OP_REM   = 5'h16,
    OP_REMU  = 5'h17
  } alu_op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } alu_state_e;

  function automatic logic is_iter_op(alu_op_e op);
    return (op == OP_MUL) || (op == OP_DIV) || (op == OP_DIVU) ||
           (op == OP_REM) || (op == OP_REMU);
  endfunction

  function automatic logic is_signed_div(alu_op_e op);
    return (op == OP_DIV) || (op == OP_REM);
  endfunction

endpackage

// File: rtl/alu_iter_if.sv
// Request/response handshake bundle between an ALU client and alu_iter.
interface alu_iter_if #(parameter int XLEN = 32);
  logic            in_valid;
  logic            in_ready;
  logic [4:0]      ALU_op;
  logic [XLEN-1:0] input1;
  logic [XLEN-1:0] input2;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] alu_out;
  logic            zero;

  modport master (
    output in_valid, ALU_op, input1, input2, out_ready,
    input  in_ready, out_valid, alu_out, zero
  );

  modport slave (
    input  in_valid, ALU_op, input1, input2, out_ready,
    output in_ready, out_valid, alu_out, zero
  );
endinterface

// File: rtl/alu_muldiv_iter.sv
// Bit-serial multiply (shift-add) and restoring divide, one bit per cycle.
module alu_muldiv_iter
  import alu_pkg::*;
#(
  parameter int XLEN    = XLEN_DEFAULT,
  parameter int SHAMT_W = $clog2(XLEN)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            start,
  input  alu_op_e         op,
  input  logic [XLEN-1:0] opa,
  input  logic [XLEN-1:0] opb,
  output logic            done,
  output logic [XLEN-1:0] result
);

  logic               busy;
  logic [SHAMT_W-1:0] cnt;
  alu_op_e            op_q;
  logic [XLEN-1:0]    a_q;    // multiplicand, or dividend shifting into quotient
  logic [XLEN-1:0]    b_q;    // multiplier, or divisor magnitude
  logic [XLEN-1:0]    acc_q;  // partial product, or partial remainder
  logic               neg_q;
  logic               neg_r;

  logic            a_neg, b_neg;
  logic [XLEN:0]   shifted, diff;
  logic            fits;
  logic [XLEN-1:0] rem_n, quo_n, prod_n;

  assign a_neg = is_signed_div(op) && opa[XLEN-1];
  assign b_neg = is_signed_div(op) && opb[XLEN-1];

  assign shifted = {acc_q, a_q[XLEN-1]};
  assign diff    = shifted - {1'b0, b_q};
  assign fits    = !diff[XLEN];
  assign rem_n   = fits ? diff[XLEN-1:0] : shifted[XLEN-1:0];
  assign quo_n   = {a_q[XLEN-2:0], fits};
  assign prod_n  = acc_q + (b_q[0] ? a_q : '0);

  assign done = busy && (cnt == SHAMT_W'(XLEN-1));

  // Result reflects the step being taken this cycle, so it is final when done is high.
  always_comb begin
    result = '0;
    case (op_q)
      OP_MUL:          result = prod_n;
      OP_DIV, OP_DIVU: result = neg_q ? -quo_n : quo_n;
      OP_REM, OP_REMU: result = neg_r ? -rem_n : rem_n;
      default:         result = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      busy  <= 1'b0;
      cnt   <= '0;
      op_q  <= OP_LUI;
      a_q   <= '0;
      b_q   <= '0;
      acc_q <= '0;
      neg_q <= 1'b0;
      neg_r <= 1'b0;
    end else if (flush) begin
      busy <= 1'b0;
      cnt  <= '0;
    end else if (start) begin
      busy  <= 1'b1;
      cnt   <= '0;
      op_q  <= op;
      acc_q <= '0;
      neg_q <= a_neg ^ b_neg;
      neg_r <= a_neg;
      if (op == OP_MUL) begin
        a_q <= opa;
        b_q <= opb;
      end else begin
        a_q <= a_neg ? -opa : opa;
        b_q <= b_neg ? -opb : opb;
      end
    end else if (busy) begin
      cnt <= cnt + SHAMT_W'(1);
      if (done) begin
        busy <= 1'b0;
        cnt  <= '0;
      end
      if (op_q == OP_MUL) begin
        acc_q <= prod_n;
        a_q   <= a_q << 1;
        b_q   <= b_q >> 1;
      end else begin
        acc_q <= rem_n;
        a_q   <= quo_n;
      end
    end
  end

endmodule

// File: rtl/alu_iter.sv
// ALU with single-cycle legacy ops and iterative mul/div behind a valid/ready handshake.
//   state  | meaning
//   IDLE   | ready for a request
//   BUSY   | mul/div iterating, one bit per cycle
//   DONE   | result valid, held until out_ready
module alu_iter
  import alu_pkg::*;
#(
  parameter int XLEN    = XLEN_DEFAULT,
  parameter int SHAMT_W = $clog2(XLEN)
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  alu_iter_if.slave   bus
);

  alu_state_e         state;
  alu_op_e            op;
  logic [XLEN-1:0]    a, b;
  logic [SHAMT_W-1:0] shamt;
  logic [XLEN-1:0]    sc_out;
  logic               sc_zero;
  logic               div_zero, div_ovf, iter_go, accept;
  logic               md_start, md_done;
  logic [XLEN-1:0]    md_result;

  assign op    = alu_op_e'(bus.ALU_op);
  assign a     = bus.input1;
  assign b     = bus.input2;
  assign shamt = b[SHAMT_W-1:0];

  assign div_zero = (b == '0);
  assign div_ovf  = is_signed_div(op) && (a == {1'b1, {(XLEN-1){1'b0}}}) && (b == '1);
  // Divide-by-zero and signed overflow resolve in one cycle instead of iterating.
  assign iter_go  = is_iter_op(op) && ((op == OP_MUL) || !(div_zero || div_ovf));

  assign bus.in_ready = (state == S_IDLE) && !flush && !rst;
  assign accept       = bus.in_valid && bus.in_ready;
  assign md_start     = accept && iter_go;

  always_comb begin
    sc_out  = '0;
    sc_zero = 1'b0;
    case (op)
      OP_LUI:          sc_out  = b;
      OP_AUIPC,
      OP_ADD:          sc_out  = a + b;
      OP_BEQ:          sc_zero = (a == b);
      OP_BNE:          sc_zero = (a != b);
      OP_BLT:          sc_zero = ($signed(a) < $signed(b));
      OP_BGE:          sc_zero = ($signed(a) >= $signed(b));
      OP_BLTU:         sc_zero = (a < b);
      OP_BGEU:         sc_zero = (a >= b);
      OP_SLT:          sc_out  = {{(XLEN-1){1'b0}}, ($signed(a) < $signed(b))};
      OP_SLTU:         sc_out  = {{(XLEN-1){1'b0}}, (a < b)};
      OP_XOR:          sc_out  = a ^ b;
      OP_OR:           sc_out  = a | b;
      OP_AND:          sc_out  = a & b;
      OP_SLL:          sc_out  = a << shamt;
      OP_SRL:          sc_out  = a >> shamt;
      OP_SRA:          sc_out  = $signed(a) >>> shamt;
      OP_SUB:          sc_out  = a - b;
      OP_DIV, OP_DIVU: sc_out  = div_zero ? '1 : a;
      OP_REM, OP_REMU: sc_out  = div_zero ? a : '0;
      default:         sc_out  = '0;
    endcase
  end

  alu_muldiv_iter #(
    .XLEN    (XLEN),
    .SHAMT_W (SHAMT_W)
  ) u_muldiv (
    .clk    (clk),
    .rst    (rst),
    .flush  (flush),
    .start  (md_start),
    .op     (op),
    .opa    (a),
    .opb    (b),
    .done   (md_done),
    .result (md_result)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= S_IDLE;
      bus.alu_out   <= '0;
      bus.zero      <= 1'b0;
      bus.out_valid <= 1'b0;
    end else if (flush) begin
      state         <= S_IDLE;
      bus.out_valid <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (accept) begin
            if (iter_go) begin
              state <= S_BUSY;
            end else begin
              state         <= S_DONE;
              bus.alu_out   <= sc_out;
              bus.zero      <= sc_zero;
              bus.out_valid <= 1'b1;
            end
          end
        end
        S_BUSY: begin
          if (md_done) begin
            state         <= S_DONE;
            bus.alu_out   <= md_result;
            bus.zero      <= 1'b0;
            bus.out_valid <= 1'b1;
          end
        end
        S_DONE: begin
          if (bus.out_ready) begin
            state         <= S_IDLE;
            bus.out_valid <= 1'b0;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_iter.sv
// Self-checking bench for alu_iter: directed vector table, handshake corner cases, random ops.
module tb_alu_iter;
  import alu_pkg::*;

  localparam int XLEN = 32;
  localparam int ITER_LAT = XLEN + 1;

  logic clk = 1'b0;
  logic rst;
  logic flush;

  alu_iter_if #(.XLEN(XLEN)) bus();

  alu_iter #(.XLEN(XLEN)) dut (
    .clk   (clk),
    .rst   (rst),
    .flush (flush),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;

  typedef struct {
    logic [4:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] r;
    logic        z;
    int          lat;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, got, exp);
  endtask

  function automatic void add_vec(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                                  input logic [31:0] r, input logic z, input int lat);
    vec_t v;
    v.op = op; v.a = a; v.b = b; v.r = r; v.z = z; v.lat = lat;
    vecs.push_back(v);
  endfunction

  // Reference model straight from the op definitions, using native SV arithmetic.
  function automatic void ref_alu(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] r, output logic z, output int lat);
    logic signed [31:0] sa, sb;
    int sh;
    sa = a; sb = b; sh = int'(b[4:0]);
    r = 32'd0; z = 1'b0; lat = 1;
    case (op)
      5'h00: r = b;
      5'h01, 5'h02: r = a + b;
      5'h03: z = (a == b);
      5'h04: z = (a != b);
      5'h05: z = (sa < sb);
      5'h06: z = (sa >= sb);
      5'h07: z = (a < b);
      5'h08: z = (a >= b);
      5'h09: r = (sa < sb) ? 32'd1 : 32'd0;
      5'h0A: r = (a < b) ? 32'd1 : 32'd0;
      5'h0B: r = a ^ b;
      5'h0C: r = a | b;
      5'h0D: r = a & b;
      5'h0E: r = a << sh;
      5'h0F: r = a >> sh;
      5'h10: r = sa >>> sh;
      5'h11: r = a - b;
      5'h13: begin r = a * b; lat = ITER_LAT; end
      5'h14: if (b == 0) r = '1;
             else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = a;
             else begin r = sa / sb; lat = ITER_LAT; end
      5'h15: if (b == 0) r = '1; else begin r = a / b; lat = ITER_LAT; end
      5'h16: if (b == 0) r = a;
             else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = 32'd0;
             else begin r = sa % sb; lat = ITER_LAT; end
      5'h17: if (b == 0) r = a; else begin r = a % b; lat = ITER_LAT; end
      default: ;
    endcase
  endfunction

  task automatic wait_ready();
    int n = 0;
    while (!bus.in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!bus.in_ready) begin
      n_total++;
      $display("FAIL wait_ready: in_ready stuck at %0b, required 1", bus.in_ready);
    end
  endtask

  // Issue one op at a negedge and return result plus cycles from acceptance to out_valid.
  task automatic run_op(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] r, output logic z, output int lat);
    wait_ready();
    bus.in_valid = 1'b1;
    bus.ALU_op   = op;
    bus.input1   = a;
    bus.input2   = b;
    @(posedge clk);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
      if (lat == 1) begin
        bus.in_valid = 1'b0;
        bus.ALU_op   = 5'($urandom);
        bus.input1   = $urandom;
        bus.input2   = $urandom;
      end
    end while (!bus.out_valid && lat < 100);
    r = bus.alu_out;
    z = bus.zero;
    bus.out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.out_ready = 1'b0;
  endtask

  initial begin
    #900000;
    $display("FAIL global_timeout: simulation did not finish, required finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] r, er;
    logic        z, ez;
    int          lat, elat;
    logic [4:0]  op;
    logic [31:0] a, b;
    logic        saw_valid;

    rst = 1'b1; flush = 1'b0;
    bus.in_valid = 1'b0; bus.out_ready = 1'b0;
    bus.ALU_op = 5'h0; bus.input1 = '0; bus.input2 = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst_in_ready",  bus.in_ready,  1);
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_alu_out",   bus.alu_out,   0);
    check("rst_zero",      bus.zero,      0);
    @(negedge clk);

    add_vec(5'h02, 32'd5,          32'd7,          32'd12,         1'b0, 1);
    add_vec(5'h05, 32'hFFFF_FFFF,  32'd1,          32'd0,          1'b1, 1);
    add_vec(5'h07, 32'hFFFF_FFFF,  32'd1,          32'd0,          1'b0, 1);
    add_vec(5'h14, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD,  1'b0, ITER_LAT);
    add_vec(5'h16, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFF,  1'b0, ITER_LAT);
    add_vec(5'h15, 32'd9,          32'd0,          32'hFFFF_FFFF,  1'b0, 1);
    add_vec(5'h14, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  1'b0, 1);
    add_vec(5'h16, 32'h8000_0000,  32'hFFFF_FFFF,  32'd0,          1'b0, 1);
    add_vec(5'h17, 32'd9,          32'd0,          32'd9,          1'b0, 1);
    add_vec(5'h13, 32'd6,          32'd7,          32'd42,         1'b0, ITER_LAT);
    add_vec(5'h11, 32'd5,          32'd7,          32'hFFFF_FFFE,  1'b0, 1);
    add_vec(5'h10, 32'h8000_0000,  32'd4,          32'hF800_0000,  1'b0, 1);
    add_vec(5'h0E, 32'd1,          32'd33,         32'd2,          1'b0, 1);
    add_vec(5'h03, 32'd3,          32'd3,          32'd0,          1'b1, 1);
    add_vec(5'h08, 32'd1,          32'hFFFF_FFFF,  32'd0,          1'b0, 1);
    add_vec(5'h00, 32'd0,          32'h1234_5000,  32'h1234_5000,  1'b0, 1);
    add_vec(5'h12, 32'd77,         32'd88,         32'd0,          1'b0, 1);
    add_vec(5'h1F, 32'd77,         32'd88,         32'd0,          1'b0, 1);
    add_vec(5'h15, 32'hFFFF_FFFF,  32'd3,          32'h5555_5555,  1'b0, ITER_LAT);
    add_vec(5'h17, 32'd100,        32'd7,          32'd2,          1'b0, ITER_LAT);
    add_vec(5'h09, 32'hFFFF_FFFF,  32'd1,          32'd1,          1'b0, 1);

    foreach (vecs[i]) begin
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, r, z, lat);
      check($sformatf("vec%0d_out", i),  r,   vecs[i].r);
      check($sformatf("vec%0d_zero", i), z,   vecs[i].z);
      check($sformatf("vec%0d_lat", i),  lat, vecs[i].lat);
    end

    // Result held under backpressure while new requests are ignored.
    wait_ready();
    bus.in_valid = 1'b1; bus.ALU_op = 5'h13; bus.input1 = 32'd6; bus.input2 = 32'd7;
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    lat = 1;
    while (!bus.out_valid && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    check("hold_lat", lat, ITER_LAT);
    for (int k = 0; k < 5; k++) begin
      bus.in_valid = 1'b1; bus.ALU_op = 5'h02; bus.input1 = 32'd1; bus.input2 = 32'd1;
      @(negedge clk);
      check($sformatf("hold%0d_out", k),   bus.alu_out,   42);
      check($sformatf("hold%0d_valid", k), bus.out_valid, 1);
      check($sformatf("hold%0d_ready", k), bus.in_ready,  0);
    end
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.out_ready = 1'b0;
    check("hold_release_valid", bus.out_valid, 0);
    check("hold_release_ready", bus.in_ready,  1);
    @(negedge clk);
    check("hold_no_stray_accept", bus.out_valid, 0);

    // Flush wins over a simultaneous request.
    flush = 1'b1; bus.in_valid = 1'b1; bus.ALU_op = 5'h02; bus.input1 = 32'd1; bus.input2 = 32'd2;
    #1;
    check("flush_blocks_ready", bus.in_ready, 0);
    @(negedge clk);
    flush = 1'b0; bus.in_valid = 1'b0;
    #1;
    check("flush_no_accept", bus.out_valid, 0);
    @(negedge clk);

    // Flush at BUSY cycle 10, then reset mid-BUSY of the next op.
    saw_valid = 1'b0;
    bus.in_valid = 1'b1; bus.ALU_op = 5'h15; bus.input1 = 32'd1000; bus.input2 = 32'd3;
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    check("flush_busy_ready", bus.in_ready, 0);
    for (int k = 1; k < 10; k++) begin
      @(negedge clk);
      saw_valid |= bus.out_valid;
    end
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    #1;
    check("flush_to_idle", bus.in_ready,  1);
    check("flush_valid",   bus.out_valid, 0);
    @(negedge clk);
    bus.in_valid = 1'b1; bus.ALU_op = 5'h15; bus.input1 = 32'd1000; bus.input2 = 32'd3;
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      saw_valid |= bus.out_valid;
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst_busy_ready",   bus.in_ready,  1);
    check("rst_busy_valid",   bus.out_valid, 0);
    check("rst_busy_alu_out", bus.alu_out,   0);
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      saw_valid |= bus.out_valid;
    end
    check("abort_never_valid", saw_valid, 0);

    // Post-abort op must start clean.
    run_op(5'h15, 32'd1000, 32'd3, r, z, lat);
    check("post_abort_out", r,   333);
    check("post_abort_lat", lat, ITER_LAT);

    for (int i = 0; i < 300; i++) begin
      op = 5'($urandom_range(0, 31));
      if ($urandom_range(0, 1) == 1) op = 5'($urandom_range(19, 23));
      a = $urandom;
      b = $urandom;
      case ($urandom_range(0, 5))
        0: b = 32'($urandom_range(0, 3));
        1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
        2: begin a = 32'($urandom_range(0, 200)); b = 32'($urandom_range(1, 20)); end
        3: b = -32'($urandom_range(1, 20));
        default: ;
      endcase
      ref_alu(op, a, b, er, ez, elat);
      run_op(op, a, b, r, z, lat);
      check($sformatf("rnd%0d_op%0h_out", i, op),  r,   er);
      check($sformatf("rnd%0d_op%0h_zero", i, op), z,   ez);
      check($sformatf("rnd%0d_op%0h_lat", i, op),  lat, elat);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/alu_iter.md
ALU_ITER -- requirements
Module: alu_iter

Interface
REQ-001 SHALL have parameter XLEN, default 32, operand/result width; legal values 16, 32, 64.
REQ-002 SHALL have parameter SHAMT_W, default $clog2(XLEN), shift-amount width taken from input2 LSBs.
REQ-003 SHALL have port clk  input  1  single clock; all state changes on rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port flush  input  1  drops any in-flight or held operation.
REQ-006 SHALL have port in_valid  input  1  operation request valid.
REQ-007 SHALL have port in_ready  output  1  unit accepts a request this cycle.
REQ-008 SHALL have port ALU_op  input  5  operation code (encodings in alu_pkg).
REQ-009 SHALL have port input1  input  XLEN  operand A (rs1/PC).
REQ-010 SHALL have port input2  input  XLEN  operand B (rs2/immediate).
REQ-011 SHALL have port out_valid  output  1  result valid.
REQ-012 SHALL have port out_ready  input  1  consumer takes result.
REQ-013 SHALL have port alu_out  output  XLEN  registered result.
REQ-014 SHALL have port zero  output  1  registered branch-taken flag.

Function
REQ-015 SHALL accept a request when in_valid && in_ready; in_ready = 1 only in state IDLE and not flush.
REQ-016 SHALL register ALU_op, input1, input2 on acceptance; later input changes SHALL not affect the result.
REQ-017 SHALL keep legacy encodings 5'h00-5'h12 (LUI, AUIPC, ADD, BEQ..BGEU, SLT, SLTU, XOR, OR, AND, SLL, SRL, SRA, SUB, 5'h12 = result 0) with unchanged semantics at width XLEN.
REQ-018 SHALL add iterative ops: 5'h13 MUL (low XLEN bits), 5'h14 DIV, 5'h15 DIVU, 5'h16 REM, 5'h17 REMU.
REQ-019 SHALL drive zero = 0 for every non-branch op and alu_out = 0 for every branch op (no stale latching).
REQ-020 SHALL return alu_out = 0, zero = 0 for undefined codes 5'h18-5'h1F, latency 1.
REQ-021 SHALL use FSM states IDLE, BUSY, DONE: IDLE->DONE on accepting a single-cycle op; IDLE->BUSY on accepting an iterative op; BUSY->DONE when iteration counter reaches XLEN-1; DONE->IDLE when out_ready.
REQ-022 SHALL assert out_valid exactly in DONE; single-cycle op result valid 1 cycle after acceptance; iterative op result valid XLEN+1 cycles after acceptance.
REQ-023 SHALL hold alu_out, zero, out_valid stable in DONE until out_ready is sampled high.
REQ-024 SHALL implement MUL as shift-add and DIV/REM as restoring division, one bit per BUSY cycle, using a counter of width SHAMT_W.
REQ-025 SHALL handle divide by zero in 1 cycle (IDLE->DONE): DIV/DIVU result all ones, REM/REMU result = input1.
REQ-026 SHALL handle signed overflow (input1 = most-negative, input2 = -1) in 1 cycle: DIV result = input1, REM result 0.
REQ-027 SHALL give signed DIV truncation toward zero; REM sign equal to dividend sign.
REQ-028 SHALL on flush in any state go to IDLE next cycle, deassert out_valid, clear the counter; flush has priority over acceptance and out_ready.
REQ-029 SHALL ignore in_valid while in BUSY or DONE.

Reset
REQ-030 SHALL on rst go to IDLE with out_valid = 0, alu_out = 0, zero = 0, counter = 0, operand registers = 0; in_ready = 1 the cycle after rst deasserts.
REQ-031 SHALL give rst priority over flush and all handshakes, including mid-BUSY.

Structure
REQ-032 SHALL place op encodings, FSM state encoding and the XLEN default in shared package alu_pkg.
REQ-033 SHALL put the iterative multiply/divide datapath in one sub-module alu_muldiv_iter (start, op, operands -> done, result); single-cycle ops stay in alu_iter.

Verification
REQ-034 SHALL cover: accept ADD 5 + 7 -> out_valid next cycle, alu_out = 12, zero = 0.
REQ-035 SHALL cover: BLT input1 = 32'hFFFFFFFF, input2 = 1 -> zero = 1, alu_out = 0; BLTU same operands -> zero = 0.
REQ-036 SHALL cover: DIV -7 / 2 -> out_valid 33 cycles after acceptance (XLEN = 32), alu_out = -3; REM -> -1.
REQ-037 SHALL cover: DIVU 9 / 0 -> alu_out = 32'hFFFFFFFF at latency 1; DIV 32'h80000000 / -1 -> 32'h80000000.
REQ-038 SHALL cover: out_ready low 5 cycles after MUL 6 * 7 -> alu_out = 42 held, in_ready = 0 throughout.
REQ-039 SHALL cover: flush at BUSY cycle 10 of DIVU, then rst during next BUSY -> IDLE next cycle each time, out_valid never asserted.
